// File: rtl/ifid_skid_reg.sv
// IF/ID pipeline register with a two-entry skid buffer, flush-to-bubble, registered stall flag
// and a saturating stall-cycle counter.
module ifid_skid_reg #(
  parameter int unsigned         PC_W     = 16,
  parameter int unsigned         INST_W   = 16,
  parameter logic [INST_W-1:0]   NOP_INST = '0,
  parameter int unsigned         CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  input  logic              in_exec,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic              out_exec,
  output logic              stall_q,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_valid_q, main_valid_d;
  logic [PC_W-1:0]   main_pc_q,    main_pc_d;
  logic [INST_W-1:0] main_inst_q,  main_inst_d;
  logic              main_exec_q,  main_exec_d;

  logic              skid_valid_q, skid_valid_d;
  logic [PC_W-1:0]   skid_pc_q,    skid_pc_d;
  logic [INST_W-1:0] skid_inst_q,  skid_inst_d;
  logic              skid_exec_q,  skid_exec_d;

  logic              stall_dly_q,  stall_dly_d;
  logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;

  logic in_fire;
  logic out_fire;

  // in_ready comes straight from a flop so fetch never sees a path from out_ready.
  assign in_ready = !skid_valid_q;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = main_valid_q && out_ready && !stall;

  always_comb begin
    main_valid_d = main_valid_q;
    main_pc_d    = main_pc_q;
    main_inst_d  = main_inst_q;
    main_exec_d  = main_exec_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_inst_d  = skid_inst_q;
    skid_exec_d  = skid_exec_q;

    if (flush) begin
      // Data fields stay stale; the output masks hide them.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q) begin
      if (in_fire) begin
        main_valid_d = 1'b1;
        main_pc_d    = in_pc;
        main_inst_d  = in_inst;
        main_exec_d  = in_exec;
      end
    end else if (out_fire) begin
      if (skid_valid_q) begin
        main_pc_d    = skid_pc_q;
        main_inst_d  = skid_inst_q;
        main_exec_d  = skid_exec_q;
        skid_valid_d = in_fire;
        if (in_fire) begin
          skid_pc_d   = in_pc;
          skid_inst_d = in_inst;
          skid_exec_d = in_exec;
        end
      end else if (in_fire) begin
        main_pc_d   = in_pc;
        main_inst_d = in_inst;
        main_exec_d = in_exec;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_pc_d    = in_pc;
      skid_inst_d  = in_inst;
      skid_exec_d  = in_exec;
    end
  end

  always_comb begin
    stall_dly_d = flush ? 1'b0 : stall;
    stall_cnt_d = stall_cnt_q;
    if (stall && main_valid_q && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_pc_q    <= '0;
      main_inst_q  <= '0;
      main_exec_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_inst_q  <= '0;
      skid_exec_q  <= 1'b0;
      stall_dly_q  <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_pc_q    <= main_pc_d;
      main_inst_q  <= main_inst_d;
      main_exec_q  <= main_exec_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_inst_q  <= skid_inst_d;
      skid_exec_q  <= skid_exec_d;
      stall_dly_q  <= stall_dly_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out_pc    = main_pc_q;
  assign out_inst  = main_valid_q ? main_inst_q : NOP_INST;
  assign out_exec  = main_valid_q && main_exec_q;
  assign stall_q   = stall_dly_q;
  assign stall_cnt = stall_cnt_q;

  // The skid slot is only ever filled behind an occupied main slot.
  skid_behind_main: assert property (@(posedge clk) disable iff (rst)
    skid_valid_q |-> main_valid_q);

  // A presented beat holds bit-for-bit until it is taken or squashed.
  hold_until_fire: assert property (@(posedge clk) disable iff (rst)
    (main_valid_q && !out_fire && !flush) |=>
      (main_valid_q && $stable({main_pc_q, main_inst_q, main_exec_q})));

endmodule

// File: tb/tb_ifid_skid_reg.sv
// Bench for ifid_skid_reg: directed vector table, hand-written corner sequences and a random run
// against a queue-based model. A second instance with a 2-bit counter shares the stimulus.
module tb_ifid_skid_reg;

  localparam logic [15:0] NOP = 16'hF00F;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_exec, stall, flush, out_ready;
  logic [15:0] in_pc, in_inst;
  logic        in_ready, out_valid, out_exec, stall_q;
  logic [15:0] out_pc, out_inst;
  logic [7:0]  stall_cnt;
  logic        d2_in_ready, d2_out_valid, d2_out_exec, d2_stall_q;
  logic [15:0] d2_out_pc, d2_out_inst;
  logic [1:0]  d2_stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ifid_skid_reg #(.PC_W(16), .INST_W(16), .NOP_INST(NOP), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .in_exec(in_exec), .stall(stall), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst), .out_exec(out_exec),
    .stall_q(stall_q), .stall_cnt(stall_cnt)
  );

  ifid_skid_reg #(.PC_W(16), .INST_W(16), .NOP_INST(NOP), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d2_in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .in_exec(in_exec), .stall(stall), .flush(flush),
    .out_valid(d2_out_valid), .out_ready(out_ready), .out_pc(d2_out_pc),
    .out_inst(d2_out_inst), .out_exec(d2_out_exec), .stall_q(d2_stall_q),
    .stall_cnt(d2_stall_cnt)
  );

  // Behavioural model: the stage is a FIFO of at most two beats.
  typedef struct {
    logic [15:0] pc;
    logic [15:0] inst;
    logic        exec;
  } beat_t;

  beat_t       m_q[$];
  logic [15:0] m_last_pc = '0;
  logic        m_stall_q = 1'b0;
  int          m_cnt8 = 0;
  int          m_cnt2 = 0;

  task automatic model_step();
    bit    ofire, ifire;
    beat_t b;
    if (rst) begin
      m_q.delete();
      m_last_pc = '0;
      m_stall_q = 1'b0;
      m_cnt8    = 0;
      m_cnt2    = 0;
    end else begin
      if (stall && m_q.size() > 0) begin
        m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
        m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
      end
      m_stall_q = flush ? 1'b0 : stall;
      if (flush) begin
        m_q.delete();
      end else begin
        ofire = (m_q.size() > 0) && out_ready && !stall;
        ifire = in_valid && (m_q.size() < 2);
        if (ofire) void'(m_q.pop_front());
        if (ifire) begin
          b.pc   = in_pc;
          b.inst = in_inst;
          b.exec = in_exec;
          m_q.push_back(b);
        end
      end
      if (m_q.size() > 0) m_last_pc = m_q[0].pc;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [15:0] pc,
                       input logic [15:0] inst, input logic ex, input logic st,
                       input logic fl, input logic ordy);
    rst = r; in_valid = iv; in_pc = pc; in_inst = inst; in_exec = ex;
    stall = st; flush = fl; out_ready = ordy;
  endtask

  task automatic model_check(input int cyc);
    bit nonempty;
    nonempty = m_q.size() > 0;
    chk($sformatf("rand%0d out_valid", cyc), out_valid, nonempty);
    chk($sformatf("rand%0d in_ready", cyc), in_ready, m_q.size() < 2);
    chk($sformatf("rand%0d out_pc", cyc), out_pc, m_last_pc);
    chk($sformatf("rand%0d out_inst", cyc), out_inst, nonempty ? m_q[0].inst : NOP);
    chk($sformatf("rand%0d out_exec", cyc), out_exec, nonempty ? m_q[0].exec : 1'b0);
    chk($sformatf("rand%0d stall_q", cyc), stall_q, m_stall_q);
    chk($sformatf("rand%0d stall_cnt", cyc), stall_cnt, m_cnt8);
    chk($sformatf("rand%0d stall_cnt2", cyc), d2_stall_cnt, m_cnt2);
  endtask

  typedef struct {
    logic        rst, iv;
    logic [15:0] pc, inst;
    logic        ex, st, fl, ordy;
    logic        ov, ir;
    logic [15:0] opc, oinst;
    logic        oex, osq;
    logic [7:0]  ocnt;
  } vec_t;

  function automatic vec_t v(logic r, logic iv, logic [15:0] pc, logic [15:0] inst, logic ex,
                             logic st, logic fl, logic ordy, logic ov, logic ir,
                             logic [15:0] opc, logic [15:0] oinst, logic oex, logic osq,
                             logic [7:0] ocnt);
    vec_t x;
    x.rst = r; x.iv = iv; x.pc = pc; x.inst = inst; x.ex = ex; x.st = st; x.fl = fl;
    x.ordy = ordy; x.ov = ov; x.ir = ir; x.opc = opc; x.oinst = oinst; x.oex = oex;
    x.osq = osq; x.ocnt = ocnt;
    return x;
  endfunction

  vec_t vecs[$];
  int   exp2[6] = '{1, 2, 3, 3, 3, 3};

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);

    //                  rst iv pc       inst     ex st fl rdy  ov ir opc      oinst    ex sq cnt
    vecs.push_back(v(1, 0, 16'h0000, 16'h0000, 0, 0, 0, 0,  0, 1, 16'h0000, NOP,     0, 0, 0));
    vecs.push_back(v(0, 1, 16'h0001, 16'hA001, 1, 0, 0, 1,  1, 1, 16'h0001, 16'hA001, 1, 0, 0));
    vecs.push_back(v(0, 1, 16'h0002, 16'hA002, 1, 0, 0, 1,  1, 1, 16'h0002, 16'hA002, 1, 0, 0));
    vecs.push_back(v(0, 1, 16'h0003, 16'hA003, 1, 0, 0, 1,  1, 1, 16'h0003, 16'hA003, 1, 0, 0));
    vecs.push_back(v(0, 1, 16'h0004, 16'hA004, 1, 0, 0, 1,  1, 1, 16'h0004, 16'hA004, 1, 0, 0));
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1,  0, 1, 16'h0004, NOP,     0, 0, 0));
    // Stall with a beat held; fetch keeps offering.
    vecs.push_back(v(0, 1, 16'h0010, 16'hB010, 0, 0, 0, 1,  1, 1, 16'h0010, 16'hB010, 0, 0, 0));
    vecs.push_back(v(0, 1, 16'h0011, 16'hB011, 1, 1, 0, 1,  1, 0, 16'h0010, 16'hB010, 0, 1, 1));
    vecs.push_back(v(0, 1, 16'h0012, 16'hB012, 0, 1, 0, 1,  1, 0, 16'h0010, 16'hB010, 0, 1, 2));
    vecs.push_back(v(0, 1, 16'h0012, 16'hB012, 0, 1, 0, 1,  1, 0, 16'h0010, 16'hB010, 0, 1, 3));
    vecs.push_back(v(0, 1, 16'h0012, 16'hB012, 0, 0, 0, 1,  1, 1, 16'h0011, 16'hB011, 1, 0, 3));
    vecs.push_back(v(0, 1, 16'h0012, 16'hB012, 0, 0, 0, 1,  1, 1, 16'h0012, 16'hB012, 0, 0, 3));
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1,  0, 1, 16'h0012, NOP,     0, 0, 3));
    // out_ready low, two beats: second one skids.
    vecs.push_back(v(0, 1, 16'h0030, 16'hC030, 1, 0, 0, 0,  1, 1, 16'h0030, 16'hC030, 1, 0, 3));
    vecs.push_back(v(0, 1, 16'h0031, 16'hC031, 0, 0, 0, 0,  1, 0, 16'h0030, 16'hC030, 1, 0, 3));
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1,  1, 1, 16'h0031, 16'hC031, 0, 0, 3));
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1,  0, 1, 16'h0031, NOP,     0, 0, 3));
    // Fill both entries, then flush with a beat offered.
    vecs.push_back(v(0, 1, 16'h0040, 16'hD040, 1, 0, 0, 1,  1, 1, 16'h0040, 16'hD040, 1, 0, 3));
    vecs.push_back(v(0, 1, 16'h0041, 16'hD041, 1, 1, 0, 1,  1, 0, 16'h0040, 16'hD040, 1, 1, 4));
    vecs.push_back(v(0, 1, 16'h0020, 16'hD020, 1, 1, 1, 1,  0, 1, 16'h0040, NOP,     0, 0, 5));
    vecs.push_back(v(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1,  0, 1, 16'h0040, NOP,     0, 0, 5));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].pc, vecs[i].inst, vecs[i].ex, vecs[i].st,
            vecs[i].fl, vecs[i].ordy);
      tick();
      chk($sformatf("v%0d out_valid", i), out_valid, vecs[i].ov);
      chk($sformatf("v%0d in_ready", i), in_ready, vecs[i].ir);
      chk($sformatf("v%0d out_pc", i), out_pc, vecs[i].opc);
      chk($sformatf("v%0d out_inst", i), out_inst, vecs[i].oinst);
      chk($sformatf("v%0d out_exec", i), out_exec, vecs[i].oex);
      chk($sformatf("v%0d stall_q", i), stall_q, vecs[i].osq);
      chk($sformatf("v%0d stall_cnt", i), stall_cnt, vecs[i].ocnt);
    end

    // 2-bit counter saturation over six stalled valid cycles.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("sat reset cnt2", d2_stall_cnt, 0);
    drive(0, 1, 16'h0050, 16'h5050, 1, 0, 0, 1);
    tick();
    chk("sat beat valid", d2_out_valid, 1);
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 0, 0, 0, 1, 0, 1);
      tick();
      chk($sformatf("sat cnt2[%0d]", k), d2_stall_cnt, exp2[k]);
      chk($sformatf("sat cnt8[%0d]", k), stall_cnt, k + 1);
    end

    // Reset with both entries full and stall asserted.
    drive(0, 1, 16'h0051, 16'h5051, 1, 1, 0, 1);
    tick();
    chk("rstmid full in_ready", in_ready, 0);
    drive(1, 1, 16'h0052, 16'h5052, 1, 1, 0, 1);
    tick();
    chk("rstmid out_valid", out_valid, 0);
    chk("rstmid in_ready", in_ready, 1);
    chk("rstmid out_pc", out_pc, 16'h0000);
    chk("rstmid out_inst", out_inst, NOP);
    chk("rstmid out_exec", out_exec, 0);
    chk("rstmid stall_q", stall_q, 0);
    chk("rstmid stall_cnt", stall_cnt, 0);
    drive(0, 1, 16'h0060, 16'h6060, 1, 0, 0, 1);
    tick();
    chk("post-rst out_valid", out_valid, 1);
    chk("post-rst out_pc", out_pc, 16'h0060);
    chk("post-rst out_inst", out_inst, 16'h6060);
    chk("post-rst out_exec", out_exec, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("post-rst drained", out_valid, 0);

    // Random traffic against the queue model.
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 199) == 0,
            $urandom_range(0, 9) < 7,
            16'($urandom), 16'($urandom), 1'($urandom),
            $urandom_range(0, 9) < 2,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) < 7);
      tick();
      model_check(c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
